// File: rtl/vel_ramp_gen_pkg.sv
// Shared widths, FSM state encoding and the saturating velocity adder for vel_ramp_gen.
package vel_ramp_gen_pkg;

  localparam int VEL_W   = 32;
  localparam int TICKS_W = 32;

  localparam logic [VEL_W-1:0] VEL_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [VEL_W-1:0] VEL_SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Sign-extend both operands to 33 bits so an overflow shows as bit32 != bit31.
  function automatic logic signed [VEL_W-1:0] sat_add(input logic signed [VEL_W-1:0] a,
                                                      input logic signed [VEL_W-1:0] b);
    logic [VEL_W:0] sum;
    sum = {a[VEL_W-1], a} + {b[VEL_W-1], b};
    if (sum[VEL_W] != sum[VEL_W-1]) begin
      sat_add = sum[VEL_W] ? VEL_SAT_MIN : VEL_SAT_MAX;
    end else begin
      sat_add = sum[VEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/vel_ramp_gen_seg_fifo.sv
// Synchronous segment queue with flush; level counts entries held, pointers carry a wrap bit.
module vel_ramp_gen_seg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign level     = wr_ptr_r - rd_ptr_r;
  assign empty     = (level == (AW+1)'(0));
  assign full      = (level == (AW+1)'(DEPTH));
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array: write-only on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= (AW+1)'(0);
      rd_ptr_r <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= (AW+1)'(0);
      rd_ptr_r <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/vel_ramp_gen.sv
// Segment executor feeding step_gen velocity: prescaled integrator over a queue of (accel, ticks).
// Optional |velocity| <= VMAX clamp is enabled by defining VP2_VEL_LIMIT_EN.
module vel_ramp_gen
  import vel_ramp_gen_pkg::*;
#(
  parameter int          TICK_DIV   = 1000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] VMAX       = 32'h7FFF_FFFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [VEL_W-1:0]       seg_accel,
  input  logic [TICKS_W-1:0]            seg_ticks,
  input  logic                          seg_valid,
  output logic                          seg_ready,
  input  logic                          abort,
  output logic signed [VEL_W-1:0]       velocity,
  output logic                          busy,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
`ifdef VP2_VEL_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic signed [VEL_W-1:0] VLIM_POS = VMAX;
  localparam logic signed [VEL_W-1:0] VLIM_NEG = -VLIM_POS;

  state_t                     state_r;
  logic [PW-1:0]              pre_cnt_r;
  logic                       tick_s;
  logic signed [VEL_W-1:0]    cur_accel_r;
  logic [TICKS_W-1:0]         rem_ticks_r;
  logic signed [VEL_W-1:0]    velocity_r;
  logic                       underrun_r;
  logic signed [VEL_W-1:0]    sat_vel_s;
  logic signed [VEL_W-1:0]    next_vel_s;
  logic [VEL_W+TICKS_W-1:0]   head_s;
  logic signed [VEL_W-1:0]    head_accel_s;
  logic [TICKS_W-1:0]         head_ticks_s;
  logic [LW-1:0]              level_s;
  logic                       empty_s;
  logic                       full_s;
  logic                       pop_s;

  vel_ramp_gen_seg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VEL_W + TICKS_W)
  ) u_seg_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (seg_valid),
    .push_data ({seg_accel, seg_ticks}),
    .pop       (pop_s),
    .head      (head_s),
    .flush     (abort),
    .level     (level_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  assign head_accel_s = head_s[VEL_W+TICKS_W-1:TICKS_W];
  assign head_ticks_s = head_s[TICKS_W-1:0];
  assign pop_s        = (state_r == LOAD) && !empty_s;
  assign tick_s       = (pre_cnt_r == PRE_LAST);
  assign seg_ready    = !full_s;
  assign fifo_level   = level_s;
  assign velocity     = velocity_r;
  assign underrun     = underrun_r;
  assign busy         = (state_r != IDLE) || (level_s != LW'(0));

  // Free-running tick prescaler; only abort realigns it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_r <= PW'(0);
    end else if (abort || tick_s) begin
      pre_cnt_r <= PW'(0);
    end else begin
      pre_cnt_r <= pre_cnt_r + PW'(1);
    end
  end

  // Next velocity: 32-bit saturation, then the optional magnitude clamp.
  always_comb begin
    sat_vel_s  = sat_add(velocity_r, cur_accel_r);
    next_vel_s = sat_vel_s;
    if (LIMIT_EN && (sat_vel_s > VLIM_POS)) begin
      next_vel_s = VLIM_POS;
    end else if (LIMIT_EN && (sat_vel_s < VLIM_NEG)) begin
      next_vel_s = VLIM_NEG;
    end else begin
      next_vel_s = sat_vel_s;
    end
  end

  // Segment FSM and velocity integrator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cur_accel_r <= 32'sd0;
      rem_ticks_r <= TICKS_W'(0);
      velocity_r  <= 32'sd0;
      underrun_r  <= 1'b0;
    end else if (abort) begin
      state_r     <= IDLE;
      cur_accel_r <= 32'sd0;
      rem_ticks_r <= TICKS_W'(0);
      velocity_r  <= 32'sd0;
      underrun_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) state_r <= LOAD;
        end
        LOAD: begin
          if (empty_s) begin
            state_r <= IDLE;
            if (velocity_r != 32'sd0) underrun_r <= 1'b1;
          end else if (head_ticks_s == TICKS_W'(0)) begin
            // Zero-length segment: dropped without consuming a tick.
            if (level_s > LW'(1)) begin
              state_r <= LOAD;
            end else begin
              state_r <= IDLE;
              if (velocity_r != 32'sd0) underrun_r <= 1'b1;
            end
          end else begin
            cur_accel_r <= head_accel_s;
            rem_ticks_r <= head_ticks_s;
            state_r     <= RUN;
          end
        end
        RUN: begin
          if (tick_s) begin
            velocity_r  <= next_vel_s;
            rem_ticks_r <= rem_ticks_r - TICKS_W'(1);
            if (rem_ticks_r == TICKS_W'(1)) state_r <= LOAD;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vel_ramp_gen.sv
// Self-checking bench for vel_ramp_gen (TICK_DIV=4, FIFO_DEPTH=4) with a per-tick velocity model.
module tb_vel_ramp_gen;

  localparam int TD = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [31:0] seg_accel;
  logic [31:0]        seg_ticks;
  logic               seg_valid;
  logic               seg_ready;
  logic               abort;
  logic signed [31:0] velocity;
  logic               busy;
  logic               underrun;
  logic [2:0]         fifo_level;

  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  int          origin = 0;
  logic [31:0] vel_exp = 32'd0;
  logic        und_exp = 1'b0;
  logic [31:0] sa [4];
  int          st [4];
  int          sn;

  vel_ramp_gen #(
    .TICK_DIV   (TD),
    .FIFO_DEPTH (4),
    .VMAX       (32'h7FFF_FFFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_accel  (seg_accel),
    .seg_ticks  (seg_ticks),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .abort      (abort),
    .velocity   (velocity),
    .busy       (busy),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_model(input logic [31:0] v, input logic [31:0] a);
    longint s;
    s = longint'($signed(v)) + longint'($signed(a));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Push sa/st[0..sn-1] back-to-back into an idle block and follow velocity every cycle.
  task automatic run_burst(input string tag);
    logic [31:0] incs[$];
    int idx = 0;
    int settle = 0;
    int t0 = 0;
    logic done = 1'b0;
    for (int i = 0; i < sn; i++)
      for (int k = 0; k < st[i]; k++) incs.push_back(sa[i]);
    for (int c = 0; c < 400 && !done; c++) begin
      if (c < sn) begin
        seg_accel = sa[c];
        seg_ticks = st[c];
        seg_valid = 1'b1;
        chk({tag, "_ready"}, seg_ready, 32'd1);
      end else begin
        seg_valid = 1'b0;
      end
      step();
      if (c == 0) begin
        chk({tag, "_busy_start"}, busy, 32'd1);
        t0 = edge_n + 3;
        while (((t0 - origin) % TD) != 0) t0++;
      end
      if (idx < incs.size() && edge_n >= t0 && ((edge_n - t0) % TD) == 0) begin
        vel_exp = sat_model(vel_exp, incs[idx]);
        idx++;
      end
      chk({tag, "_vel"}, velocity, vel_exp);
      if (c >= sn && idx == incs.size()) settle++;
      if (settle == 12) done = 1'b1;
    end
    seg_valid = 1'b0;
    chk({tag, "_finished"}, done, 32'd1);
    if (vel_exp != 32'd0) und_exp = 1'b1;
    chk({tag, "_busy_end"}, busy, 32'd0);
    chk({tag, "_underrun"}, underrun, und_exp);
    chk({tag, "_level_end"}, fifo_level, 32'd0);
  endtask

  task automatic do_abort(input string tag);
    abort = 1'b1;
    step();
    abort     = 1'b0;
    seg_valid = 1'b0;
    origin    = edge_n;
    vel_exp   = 32'd0;
    und_exp   = 1'b0;
    chk({tag, "_vel"}, velocity, 32'd0);
    chk({tag, "_level"}, fifo_level, 32'd0);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_underrun"}, underrun, 32'd0);
    chk({tag, "_ready"}, seg_ready, 32'd1);
  endtask

  initial begin
    int w;
    reset = 1'b0; seg_accel = 32'sd0; seg_ticks = 32'd0; seg_valid = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vel", velocity, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_underrun", underrun, 32'd0);
    chk("rst_level", fifo_level, 32'd0);
    chk("rst_ready", seg_ready, 32'd1);
    reset = 1'b1; edge_n = 0; origin = 0;

    sa[0] = 32'd1000; st[0] = 5; sn = 1;
    run_burst("ramp5");
    chk("ramp5_final", velocity, 32'd5000);

    do_abort("abort1");
    sa[0] = 32'd824633; st[0] = 1; sa[1] = -32'sd824633; st[1] = 1; sn = 2;
    run_burst("updown");
    chk("updown_final", velocity, 32'd0);

    sa[0] = 32'h7FFF_FF00; st[0] = 1; sa[1] = 32'h0000_1000; st[1] = 1; sn = 2;
    run_burst("sat");
    chk("sat_final", velocity, 32'h7FFF_FFFF);

    do_abort("abort2");
    sa[0] = 32'd500; st[0] = 2; sa[1] = 32'd777; st[1] = 0; sa[2] = 32'd300; st[2] = 2; sn = 3;
    run_burst("zero_skip");
    chk("zero_skip_final", velocity, 32'd1600);

    // Long segment keeps the block busy so the queue fills up.
    do_abort("abort3");
    seg_accel = 32'sd1000; seg_ticks = 32'd100; seg_valid = 1'b1;
    step();
    seg_valid = 1'b0;
    w = 0;
    while (velocity !== 32'sd3000 && w < 60) begin step(); w++; end
    chk("full_vel3000", velocity, 32'd3000);
    for (int i = 0; i < 4; i++) begin
      seg_accel = 32'sd5; seg_ticks = 32'd5; seg_valid = 1'b1;
      chk("full_ready_pre", seg_ready, 32'd1);
      step();
    end
    chk("full_level4", fifo_level, 32'd4);
    chk("full_ready0", seg_ready, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_level", fifo_level, 32'd4);
    end
    do_abort("mid_abort");

    seg_accel = 32'sd100; seg_ticks = 32'd50; seg_valid = 1'b1;
    step();
    seg_valid = 1'b0;
    repeat (12) step();
    chk("arst_pre_busy", busy, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_vel", velocity, 32'd0);
    chk("arst_busy", busy, 32'd0);
    chk("arst_underrun", underrun, 32'd0);
    chk("arst_level", fifo_level, 32'd0);
    chk("arst_ready", seg_ready, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; edge_n = 0; origin = 0; vel_exp = 32'd0; und_exp = 1'b0;

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0) do_abort("rnd_abort");
      sn = $urandom_range(1, 4);
      for (int i = 0; i < sn; i++) begin
        st[i] = (i == 0) ? $urandom_range(1, 4) : $urandom_range(0, 4);
        if ($urandom_range(0, 3) == 0) sa[i] = $urandom;
        else sa[i] = 32'($urandom_range(0, 4000)) - 32'd2000;
      end
      run_burst("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
